// File: rtl/fetch_unit.sv
// Instruction fetch FSM: FETCH -> CAPTURE -> HOLD, one instruction per 3 cycles; optional HALT on word 8'h00 via `FETCH_HALT_EN.
// Latency: address issued in FETCH, data sampled in CAPTURE, instr_valid rises the cycle after CAPTURE.
// Backpressure: HOLD keeps instr_out/instr_valid stable until instr_ready; branch_en redirects from any non-halt state.
module fetch_unit #(
    parameter logic [7:0] START_PC = 8'd1,
    parameter logic [7:0] END_PC   = 8'd3
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] PC_Address,
    input  logic [7:0] data_in,
    output logic [7:0] instr_out,
    output logic       instr_valid,
    input  logic       instr_ready,
    input  logic       branch_en,
    input  logic [7:0] branch_target,
    output logic       halted
);

    localparam logic [1:0] FETCH   = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;
`ifdef FETCH_HALT_EN
    localparam logic [1:0] HALT    = 2'd3;
`endif

    logic [1:0] state;
    logic [7:0] seq_pc;

    // PC_Address is the PC register itself; no separate copy to keep in sync.
    assign seq_pc = (PC_Address == END_PC) ? START_PC : PC_Address + 8'd1;

`ifdef FETCH_HALT_EN
    logic halted_q;
    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            PC_Address  <= START_PC;
            instr_out   <= 8'h00;
            instr_valid <= 1'b0;
`ifdef FETCH_HALT_EN
            halted_q    <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    if (branch_en) begin
                        PC_Address <= branch_target;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (branch_en) begin
                        PC_Address <= branch_target;
                        state      <= FETCH;
                    end else begin
                        instr_out   <= data_in;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    // A branch also consumes the held instruction; redirect wins over advance.
                    if (branch_en) begin
                        PC_Address  <= branch_target;
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
`ifdef FETCH_HALT_EN
                        if (instr_out == 8'h00) begin
                            halted_q <= 1'b1;
                            state    <= HALT;
                        end else begin
                            PC_Address <= seq_pc;
                            state      <= FETCH;
                        end
`else
                        PC_Address <= seq_pc;
                        state      <= FETCH;
`endif
                    end
                end
`ifdef FETCH_HALT_EN
                HALT: begin
                    state <= HALT;
                end
`endif
                default: begin
                    instr_valid <= 1'b0;
                    state       <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, backpressure, branch redirect, reset in HOLD, halt option.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] PC_Address;
    logic [7:0] data_in;
    logic [7:0] instr_out;
    logic       instr_valid;
    logic       instr_ready;
    logic       branch_en;
    logic [7:0] branch_target;
    logic       halted;

    logic [7:0] mem [0:255];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign data_in = mem[PC_Address];

    fetch_unit #(.START_PC(8'd1), .END_PC(8'd3)) dut (
        .clk          (clk),
        .rst          (rst),
        .PC_Address   (PC_Address),
        .data_in      (data_in),
        .instr_out    (instr_out),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .branch_en    (branch_en),
        .branch_target(branch_target),
        .halted       (halted)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [7:0] exp_instr [0:3];
    logic [7:0] exp_pc    [0:3];

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'hFF;
        mem[1] = 8'h30;
        mem[2] = 8'h48;
        mem[3] = 8'h81;
        exp_instr[0] = 8'h30; exp_instr[1] = 8'h48; exp_instr[2] = 8'h81; exp_instr[3] = 8'h30;
        exp_pc[0] = 8'd1; exp_pc[1] = 8'd2; exp_pc[2] = 8'd3; exp_pc[3] = 8'd1;
        rst = 1'b1; instr_ready = 1'b1; branch_en = 1'b0; branch_target = 8'h00;

        // Reset state
        do_reset();
        check("rst_pc",     PC_Address, 8'd1);
        check("rst_instr",  instr_out, 8'h00);
        check("rst_valid",  {7'd0, instr_valid}, 8'd0);
        check("rst_halted", {7'd0, halted}, 8'd0);

        // Free-running sequence with wrap, one valid cycle per instruction
        for (int i = 0; i < 4; i++) begin
            check($sformatf("seq%0d_fetch_pc", i), PC_Address, exp_pc[i]);
            check($sformatf("seq%0d_fetch_vld", i), {7'd0, instr_valid}, 8'd0);
            step();
            check($sformatf("seq%0d_cap_vld", i), {7'd0, instr_valid}, 8'd0);
            step();
            check($sformatf("seq%0d_hold_vld", i), {7'd0, instr_valid}, 8'd1);
            check($sformatf("seq%0d_instr", i), instr_out, exp_instr[i]);
            step();
        end

        // Backpressure: hold 8'h48 for 5 cycles
        do_reset();
        step(); step(); step();
        instr_ready = 1'b0;
        step(); step();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d_vld", k), {7'd0, instr_valid}, 8'd1);
            check($sformatf("bp%0d_instr", k), instr_out, 8'h48);
            check($sformatf("bp%0d_pc", k), PC_Address, 8'd2);
            if (k == 4) instr_ready = 1'b1;
            step();
        end
        check("bp_after_vld", {7'd0, instr_valid}, 8'd0);
        check("bp_after_pc",  PC_Address, 8'd3);

        // Branch during CAPTURE of address 1
        do_reset();
        step();
        branch_en = 1'b1; branch_target = 8'h03;
        step();
        branch_en = 1'b0;
        check("brc_vld0", {7'd0, instr_valid}, 8'd0);
        check("brc_pc",   PC_Address, 8'd3);
        step();
        check("brc_vld1", {7'd0, instr_valid}, 8'd0);
        step();
        check("brc_vld2",  {7'd0, instr_valid}, 8'd1);
        check("brc_instr", instr_out, 8'h81);

        // Branch + ready together in HOLD at address 2
        do_reset();
        step(); step(); step();
        step(); step();
        check("brh_instr48", instr_out, 8'h48);
        branch_en = 1'b1; branch_target = 8'h01;
        step();
        branch_en = 1'b0;
        check("brh_vld0", {7'd0, instr_valid}, 8'd0);
        check("brh_pc",   PC_Address, 8'd1);
        step(); step();
        check("brh_vld1",  {7'd0, instr_valid}, 8'd1);
        check("brh_instr", instr_out, 8'h30);

        // Reset in HOLD with a valid instruction
        do_reset();
        step(); step();
        check("rh_vld_pre", {7'd0, instr_valid}, 8'd1);
        rst = 1'b1;
        branch_en = 1'b1; branch_target = 8'h03;
        step();
        rst = 1'b0; branch_en = 1'b0;
        check("rh_vld",   {7'd0, instr_valid}, 8'd0);
        check("rh_instr", instr_out, 8'h00);
        check("rh_pc",    PC_Address, 8'd1);

        // Word 8'h00 at address 2
        mem[2] = 8'h00;
        do_reset();
        step(); step(); step();
        step(); step();
        check("z_vld",   {7'd0, instr_valid}, 8'd1);
        check("z_instr", instr_out, 8'h00);
        step();
`ifdef FETCH_HALT_EN
        check("z_halted", {7'd0, halted}, 8'd1);
        check("z_pc",     PC_Address, 8'd2);
        branch_en = 1'b1; branch_target = 8'h03;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("z_frz%0d_pc", k), PC_Address, 8'd2);
            check($sformatf("z_frz%0d_halted", k), {7'd0, halted}, 8'd1);
            check($sformatf("z_frz%0d_vld", k), {7'd0, instr_valid}, 8'd0);
        end
        branch_en = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("z_rst_halted", {7'd0, halted}, 8'd0);
        check("z_rst_pc",     PC_Address, 8'd1);
`else
        check("z_halted", {7'd0, halted}, 8'd0);
        check("z_pc",     PC_Address, 8'd3);
        step(); step();
        check("z_next_vld",   {7'd0, instr_valid}, 8'd1);
        check("z_next_instr", instr_out, 8'h81);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
